// File: rtl/poly_coef_loader_if.sv
// Coefficient stream in, coefficient RAM write port out, for poly_coef_loader.
// Handshake: a word moves on a rising edge where in_valid && in_ready; in_data must be stable while in_valid is high, and in_ready depends only on loader state, never on in_valid.
interface poly_coef_loader_if #(
  parameter int COEF_W = 13,
  parameter int ADDR_W = 11
);
  logic                     in_valid;
  logic signed [COEF_W-1:0] in_data;
  logic                     in_ready;
  logic                     mem_we;
  logic [ADDR_W-1:0]        mem_addr;
  logic [COEF_W-1:0]        mem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/poly_coef_loader.sv
// Loads P signed coefficients after the clear FSM finishes, freezes each into [0, Q)
// and writes them to the coefficient RAM in address order.
module poly_coef_loader #(
  parameter int P      = 757,
  parameter int Q      = 5167,
  parameter int COEF_W = 13,
  parameter int ADDR_W = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear_done,
  poly_coef_loader_if.slave   bus,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          fsm_state
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_CLR = 2'd1;
  localparam logic [1:0] S_LOAD     = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam int H = (Q - 1) / 2;
  localparam logic signed [COEF_W:0] H_POS = (COEF_W + 1)'(H);
  localparam logic signed [COEF_W:0] H_NEG = -H_POS;
  localparam logic [COEF_W:0]        Q_EXT = (COEF_W + 1)'(Q);
  localparam logic [ADDR_W-1:0]      LAST  = ADDR_W'(P - 1);

  logic [1:0]               state;
  logic [ADDR_W-1:0]        cnt;
  logic                     fire;
  logic signed [COEF_W:0]   data_ext;
  logic [COEF_W:0]          data_sum;
  logic                     in_range;
  logic [COEF_W-1:0]        frozen;

  assign bus.in_ready = (state == S_LOAD);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign fsm_state    = state;
  assign fire         = bus.in_valid && bus.in_ready;

  // Sign-extend by one bit so adding Q to a negative value cannot wrap before truncation.
  assign data_ext = {bus.in_data[COEF_W-1], bus.in_data};
  assign data_sum = data_ext + Q_EXT;
  assign in_range = (data_ext >= H_NEG) && (data_ext <= H_POS);

  always_comb begin
    frozen = '0;
    if (in_range) begin
      if (data_ext[COEF_W]) frozen = data_sum[COEF_W-1:0];
      else                  frozen = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      err           <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_WAIT_CLR;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        S_WAIT_CLR: begin
          if (clear_done) state <= S_LOAD;
        end
        S_LOAD: begin
          if (fire) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= cnt;
            bus.mem_wdata <= frozen;
            if (!in_range) err <= 1'b1;
            // cnt parks at P-1 so it never leaves the RAM address range.
            if (cnt == LAST) state <= S_DONE;
            else             cnt   <= cnt + ADDR_W'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_coef_loader.sv
// Randomized bench for poly_coef_loader: a write monitor collects RAM writes and
// each scenario compares them with a freeze model computed from plain integer arithmetic.
module tb_poly_coef_loader;
  localparam int P      = 757;
  localparam int Q      = 5167;
  localparam int H      = 2583;
  localparam int COEF_W = 13;
  localparam int ADDR_W = 11;

  logic clk = 1'b0;
  logic reset, start, clear_done;
  logic busy, done, err;
  logic [1:0] fsm_state;

  poly_coef_loader_if #(.COEF_W(COEF_W), .ADDR_W(ADDR_W)) bus ();

  poly_coef_loader #(.P(P), .Q(Q), .COEF_W(COEF_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clear_done (clear_done),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  int stim [P];
  logic [COEF_W-1:0] exp_q [$];
  logic              exp_err;
  logic [ADDR_W-1:0] cap_addr [$];
  logic [COEF_W-1:0] cap_data [$];
  int                cap_cyc  [$];
  int done_cnt, done_last, done_cyc;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      cap_addr.push_back(bus.mem_addr);
      cap_data.push_back(bus.mem_wdata);
      cap_cyc.push_back(cyc);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      if (bus.mem_we === 1'b1 && bus.mem_addr == ADDR_W'(P - 1)) done_last++;
    end
  end

  function automatic int freeze(input int v);
    if (v >= -H && v <= -1) return v + Q;
    if (v >= 0 && v <= H)   return v;
    return 0;
  endfunction

  task automatic build_exp();
    exp_q.delete();
    exp_err = 1'b0;
    for (int i = 0; i < P; i++) begin
      exp_q.push_back(COEF_W'(freeze(stim[i])));
      if (stim[i] > H || stim[i] < -H) exp_err = 1'b1;
    end
  endtask

  task automatic clear_cap();
    cap_addr.delete();
    cap_data.delete();
    cap_cyc.delete();
    done_cnt = 0;
    done_last = 0;
    done_cyc = -1;
  endtask

  // driver tasks
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; clear_done = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic begin_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear_done = 1'b1;
    @(posedge clk); #1;
    clear_done = 1'b0;
  endtask

  task automatic feed(input int n, input int gap_pct, input bit noise,
                      output int xfers, output int stalls);
    int idx;
    int guard;
    bit v;
    idx = 0; guard = 0; xfers = 0; stalls = 0;
    while (idx < n && guard < 20000) begin
      v = ($urandom_range(0, 99) >= gap_pct);
      bus.in_valid = v;
      bus.in_data  = COEF_W'(stim[idx]);
      if (noise) start = 1'($urandom_range(0, 1));
      if (v && bus.in_ready === 1'b1) begin
        idx++;
        xfers++;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
    n_tests++;
    if (idx !== n) begin
      n_fail++;
      $display("FAIL feed_budget transfers %0d required %0d", idx, n);
    end
  endtask

  task automatic rand_in_range();
    for (int i = 0; i < P; i++) stim[i] = $urandom_range(0, 2 * H) - H;
  endtask

  // scenarios
  task automatic test_reset();
    do_reset();
    n_tests++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", fsm_state); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", bus.in_ready); end
    n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", bus.mem_we); end
    n_tests++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", bus.mem_addr); end
    n_tests++; if (bus.mem_wdata !== '0) begin n_fail++; $display("FAIL reset_wdata got %0d exp 0", bus.mem_wdata); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
    reset = 1'b0;
  endtask

  task automatic test_wait_clr();
    do_reset(); reset = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy cyc %0d got %b exp 1", i, busy); end
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL wait_ready cyc %0d got %b exp 0", i, bus.in_ready); end
      n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL wait_we cyc %0d got %b exp 0", i, bus.mem_we); end
      @(posedge clk); #1;
    end
    start = 1'b0;
    clear_done = 1'b1;
    @(posedge clk); #1;
    clear_done = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL wait_release got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_clear_done_early();
    do_reset(); reset = 1'b0;
    clear_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL early_idle cyc %0d busy %b exp 0", i, busy); end
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL early_wait ready %b busy %b exp 0 1", bus.in_ready, busy); end
    @(posedge clk); #1;
    clear_done = 1'b0;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL early_load ready %b exp 1", bus.in_ready); end
  endtask

  task automatic test_full_load();
    int xf, st, bad;
    do_reset(); reset = 1'b0;
    for (int i = 0; i < P; i++) stim[i] = i - 378;
    build_exp();
    clear_cap();
    begin_load();
    feed(P, 0, 1'b0, xf, st);
    repeat (3) @(posedge clk); #1;
    n_tests++; if (cap_addr.size() !== P) begin n_fail++; $display("FAIL full_count got %0d exp %0d", cap_addr.size(), P); end
    bad = -1;
    for (int i = 0; i < cap_addr.size() && i < P; i++)
      if (bad < 0 && (cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== exp_q[i])) bad = i;
    n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL full_writes idx %0d got addr %0d data %0d exp addr %0d data %0d", bad, cap_addr[bad], cap_data[bad], bad, exp_q[bad]); end
    if (cap_data.size() == P) begin
      n_tests++; if (cap_data[0] !== 13'd4789) begin n_fail++; $display("FAIL full_addr0 got %0d exp 4789", cap_data[0]); end
      n_tests++; if (cap_data[378] !== 13'd0) begin n_fail++; $display("FAIL full_addr378 got %0d exp 0", cap_data[378]); end
      n_tests++; if (cap_data[756] !== 13'd378) begin n_fail++; $display("FAIL full_addr756 got %0d exp 378", cap_data[756]); end
      n_tests++; if (cap_cyc[P-1] - cap_cyc[0] !== P - 1) begin n_fail++; $display("FAIL full_b2b span %0d exp %0d", cap_cyc[P-1] - cap_cyc[0], P - 1); end
    end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_done_cnt got %0d exp 1", done_cnt); end
    n_tests++; if (done_last !== 1) begin n_fail++; $display("FAIL full_done_last got %0d exp 1", done_last); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err got %b exp 0", err); end
  endtask

  task automatic test_boundary();
    int xf, st, bad;
    do_reset(); reset = 1'b0;
    rand_in_range();
    stim[0] = -2583; stim[1] = 2583; stim[2] = -1; stim[3] = 0;
    build_exp();
    clear_cap();
    begin_load();
    feed(P, 10, 1'b0, xf, st);
    repeat (3) @(posedge clk); #1;
    bad = -1;
    for (int i = 0; i < P; i++)
      if (bad < 0 && (i >= cap_data.size() || cap_data[i] !== exp_q[i])) bad = i;
    n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL bnd_writes first bad idx %0d", bad); end
    if (cap_data.size() >= 4) begin
      n_tests++;
      if (cap_data[0] !== 13'd2584 || cap_data[1] !== 13'd2583 || cap_data[2] !== 13'd5166 || cap_data[3] !== 13'd0) begin
        n_fail++;
        $display("FAIL bnd_edges got %0d %0d %0d %0d exp 2584 2583 5166 0", cap_data[0], cap_data[1], cap_data[2], cap_data[3]);
      end
    end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL bnd_err_inrange got %b exp 0", err); end

    rand_in_range();
    stim[0] = 2584; stim[1] = -2584;
    build_exp();
    clear_cap();
    begin_load();
    feed(P, 10, 1'b0, xf, st);
    repeat (5) @(posedge clk); #1;
    if (cap_data.size() >= 2) begin
      n_tests++; if (cap_data[0] !== 13'd0 || cap_data[1] !== 13'd0) begin n_fail++; $display("FAIL bnd_oor_data got %0d %0d exp 0 0", cap_data[0], cap_data[1]); end
    end
    n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL bnd_err_sticky got %b exp %b", err, exp_err); end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL bnd_err_clear got %b exp 0", err); end
  endtask

  task automatic test_random_gaps();
    int xf, st, bad;
    int c0;
    logic signed [COEF_W-1:0] t;
    do_reset(); reset = 1'b0;
    for (int i = 0; i < P; i++) begin
      t = COEF_W'($urandom_range(0, 8191));
      stim[i] = int'(t);
    end
    build_exp();
    clear_cap();
    begin_load();
    c0 = cyc;
    feed(P, 50, 1'b0, xf, st);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL gap_done_now got %b exp 1", done); end
    repeat (3) @(posedge clk); #1;
    n_tests++; if (cap_addr.size() !== P) begin n_fail++; $display("FAIL gap_count got %0d exp %0d", cap_addr.size(), P); end
    bad = -1;
    for (int i = 0; i < cap_addr.size() && i < P; i++)
      if (bad < 0 && (cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== exp_q[i])) bad = i;
    n_tests++; if (bad !== -1) begin n_fail++; $display("FAIL gap_writes idx %0d got addr %0d data %0d exp addr %0d data %0d", bad, cap_addr[bad], cap_data[bad], bad, exp_q[bad]); end
    n_tests++; if (done_cyc - c0 + 1 !== xf + st + 1) begin n_fail++; $display("FAIL gap_cycles got %0d exp %0d", done_cyc - c0 + 1, xf + st + 1); end
    n_tests++; if (err !== exp_err) begin n_fail++; $display("FAIL gap_err got %b exp %b", err, exp_err); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL gap_done_cnt got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    int xf, st, bad, held;
    do_reset(); reset = 1'b0;
    rand_in_range();
    stim[0] = 3000;
    clear_cap();
    begin_load();
    feed(300, 0, 1'b0, xf, st);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL mid_err_pre got %b exp 1", err); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (fsm_state !== 2'd0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_idle state %0d busy %b ready %b exp 0 0 0", fsm_state, busy, bus.in_ready); end
    n_tests++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin n_fail++; $display("FAIL mid_mem we %b addr %0d data %0d exp 0 0 0", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
    n_tests++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_flags done %b err %b exp 0 0", done, err); end
    reset = 1'b0;
    held = cap_addr.size();
    repeat (5) @(posedge clk); #1;
    n_tests++; if (cap_addr.size() !== 300 || held !== 300) begin n_fail++; $display("FAIL mid_no_writes got %0d/%0d exp 300", held, cap_addr.size()); end

    rand_in_range();
    build_exp();
    clear_cap();
    begin_load();
    feed(P, 20, 1'b0, xf, st);
    repeat (3) @(posedge clk); #1;
    bad = -1;
    for (int i = 0; i < P; i++)
      if (bad < 0 && (i >= cap_addr.size() || cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== exp_q[i])) bad = i;
    n_tests++; if (bad !== -1 || cap_addr.size() !== P) begin n_fail++; $display("FAIL mid_restart first bad idx %0d count %0d exp -1 %0d", bad, cap_addr.size(), P); end
  endtask

  task automatic test_start_ignored();
    int xf, st, bad;
    do_reset(); reset = 1'b0;
    rand_in_range();
    build_exp();
    clear_cap();
    begin_load();
    feed(P, 25, 1'b1, xf, st);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (busy !== 1'b0 || fsm_state !== 2'd0) begin n_fail++; $display("FAIL ign_after_done busy %b state %0d exp 0 0", busy, fsm_state); end
    repeat (4) @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_stays_idle busy %b exp 0", busy); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_cnt got %0d exp 1", done_cnt); end
    bad = -1;
    for (int i = 0; i < P; i++)
      if (bad < 0 && (i >= cap_addr.size() || cap_addr[i] !== ADDR_W'(i) || cap_data[i] !== exp_q[i])) bad = i;
    n_tests++; if (bad !== -1 || cap_addr.size() !== P) begin n_fail++; $display("FAIL ign_writes first bad idx %0d count %0d exp -1 %0d", bad, cap_addr.size(), P); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clear_done = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    test_reset();
    test_wait_clr();
    test_clear_done_early();
    test_full_load();
    test_boundary();
    test_random_gaps();
    test_reset_mid();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
